// File: rtl/booth_seq_mult_25_pkg.sv
// rtl/booth_seq_mult_25_pkg.sv - shared widths, iteration count and FSM encoding
// for the radix-4 Booth sequential multiplier.
package booth_seq_mult_25_pkg;

  localparam int SRC_W  = 25;
  localparam int RES_W  = 50;
  localparam int ITER_N = 13;
  localparam int CNT_W  = $clog2(ITER_N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when every bit of v carries the same value, i.e. all remaining
  // Booth groups recode to a zero digit.
  function automatic logic all_same(input logic [SRC_W-1:0] v);
    return (v == '0) || (v == '1);
  endfunction

endpackage

// File: rtl/booth_seq_mult_25_if.sv
// rtl/booth_seq_mult_25_if.sv - request/response handshake bundle; master drives
// operands and response ready, slave is the multiplier.
interface booth_seq_mult_25_if;
  import booth_seq_mult_25_pkg::*;

  logic             mul_req_vld;
  logic             mul_req_rdy;
  logic [SRC_W-1:0] mul_src_a;
  logic [SRC_W-1:0] mul_src_b;
  logic             mul_flush;
  logic             mul_rsp_vld;
  logic             mul_rsp_rdy;
  logic [RES_W-1:0] mul_rsp_data;
  logic             mul_busy;

  modport master (
    output mul_req_vld, mul_src_a, mul_src_b, mul_flush, mul_rsp_rdy,
    input  mul_req_rdy, mul_rsp_vld, mul_rsp_data, mul_busy
  );

  modport slave (
    input  mul_req_vld, mul_src_a, mul_src_b, mul_flush, mul_rsp_rdy,
    output mul_req_rdy, mul_rsp_vld, mul_rsp_data, mul_busy
  );

endinterface

// File: rtl/booth_seq_mult_25_code.sv
// rtl/booth_seq_mult_25_code.sv - radix-4 Booth encoder: turns one 3-bit multiplier
// group into a 26-bit partial product (one's complement when negative) plus sign/correction.
module booth_code_25_bit
  import booth_seq_mult_25_pkg::*;
(
  input  logic [2:0]       grp_i,
  input  logic [SRC_W-1:0] a_i,
  output logic [SRC_W:0]   pp_o,
  output logic             sn_o,
  output logic             h_o
);

  logic [SRC_W:0] sel;
  logic           neg;

  always_comb begin
    sel = '0;
    neg = 1'b0;
    case (grp_i)
      3'b001, 3'b010: sel = {a_i[SRC_W-1], a_i};
      3'b011:         sel = {a_i, 1'b0};
      3'b100: begin
        sel = {a_i, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        sel = {a_i[SRC_W-1], a_i};
        neg = 1'b1;
      end
      default: begin
        sel = '0;
        neg = 1'b0;
      end
    endcase
  end

  // Negation is ~sel here; the +1 travels separately as h_o so the
  // accumulator adds it at the partial product's own weight.
  assign pp_o = neg ? ~sel : sel;
  assign sn_o = pp_o[SRC_W];
  assign h_o  = neg;

endmodule

// File: rtl/booth_seq_mult_25.sv
// rtl/booth_seq_mult_25.sv - sequential signed 25x25 radix-4 Booth multiplier, one
// partial product per cycle; BOOTH_SEQ_EARLY_TERM_EN enables early termination.
module booth_seq_mult_25
  import booth_seq_mult_25_pkg::*;
(
  input  logic               cpuclk,
  input  logic               cpurst_b,
  booth_seq_mult_25_if.slave bus
);

  state_e           state_q, state_d;
  logic [SRC_W-1:0] a_q, a_d;
  logic [SRC_W+1:0] b_q, b_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SRC_W:0]   pp;
  logic             pp_sn;
  logic             pp_h;
  logic [RES_W-1:0] pp_term;
  logic [RES_W-1:0] acc_sum;
  logic             last_iter;

  // b_q is {b[24], b, 0}, shifted right arithmetically by two each
  // iteration so the active group always sits in b_q[2:0].
  booth_code_25_bit u_code (
    .grp_i (b_q[2:0]),
    .a_i   (a_q),
    .pp_o  (pp),
    .sn_o  (pp_sn),
    .h_o   (pp_h)
  );

  assign pp_term = {{(RES_W-SRC_W-1){pp_sn}}, pp} + RES_W'(pp_h);
  assign acc_sum = acc_q + (pp_term << {cnt_q, 1'b0});

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  assign last_iter = (cnt_q == CNT_W'(ITER_N-1)) || all_same(b_q[SRC_W+1:2]);
`else
  assign last_iter = (cnt_q == CNT_W'(ITER_N-1));
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    if (bus.mul_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mul_req_vld) begin
            state_d = ST_CALC;
            a_d     = bus.mul_src_a;
            b_d     = {bus.mul_src_b[SRC_W-1], bus.mul_src_b, 1'b0};
            acc_d   = '0;
            rsp_d   = '0;
            cnt_d   = '0;
          end
        end
        ST_CALC: begin
          acc_d = acc_sum;
          b_d   = {{2{b_q[SRC_W+1]}}, b_q[SRC_W+1:2]};
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d = ST_DONE;
            rsp_d   = acc_sum;
          end
        end
        ST_DONE: begin
          if (bus.mul_rsp_rdy) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpuclk) begin
    if (!cpurst_b) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mul_req_rdy  = (state_q == ST_IDLE);
  assign bus.mul_rsp_vld  = (state_q == ST_DONE);
  assign bus.mul_busy     = (state_q != ST_IDLE);
  assign bus.mul_rsp_data = rsp_q;

endmodule

// File: doc/booth_seq_mult_25.md
BOOTH_SEQ_MULT_25 -- requirements
Module: booth_seq_mult_25

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with these ports and defaults:
- cpuclk  in  1  sole clock; all state updates on rising edge.
- cpurst_b  in  1  synchronous active-low reset.
- mul_req_vld  in  1  operand request valid.
- mul_req_rdy  out  1  block can accept; reset 1.
- mul_src_a  in  25  multiplicand, two's complement.
- mul_src_b  in  25  multiplier, two's complement.
- mul_flush  in  1  kill in-flight operation.
- mul_rsp_vld  out  1  result valid; reset 0.
- mul_rsp_rdy  in  1  consumer accepts result.
- mul_rsp_data  out  50  signed product A*B; reset 0.
- mul_busy  out  1  state != IDLE; reset 0.

Function
REQ-002 The block SHALL compute the exact 50-bit two's-complement product of the signed 25-bit operands using radix-4 Booth recoding, one partial product per cycle.
REQ-003 Multiplier recoding SHALL use groups {b[2i+1],b[2i],b[2i-1]}, i=0..12, with b[-1]=0 and b[25]=b[24]; digit d_i is in {-2,-1,0,+1,+2}.
REQ-004 Iteration i SHALL add d_i*A, weighted by 4^i, into a 50-bit accumulator; sn/h sign and negation-correction bits from the encoder SHALL be consumed so each partial product is exact; no carry SHALL be dropped.
REQ-005 The FSM SHALL have states IDLE, CALC and DONE.
REQ-006 IDLE to CALC SHALL occur on mul_req_vld & mul_req_rdy; operands are latched and the accumulator and iteration counter are cleared.
REQ-007 CALC SHALL perform exactly one iteration per cycle; after iteration 12 the FSM SHALL go to DONE.
REQ-008 mul_rsp_vld SHALL be high exactly in DONE, first 13 cycles after the accept edge.
REQ-009 In DONE, mul_rsp_data SHALL hold stable until mul_rsp_vld & mul_rsp_rdy, then the FSM SHALL go to IDLE.
REQ-010 mul_req_rdy SHALL equal (state==IDLE); there SHALL be no back-to-back accept in the response-handshake cycle.
REQ-011 mul_flush SHALL force IDLE on the next edge from any state, with no response produced; flush has priority over a simultaneous accept or response handshake.
REQ-012 Operand changes while not in IDLE SHALL have no effect.
REQ-013 mul_rsp_data SHALL be cleared to 0 on each accept.

Reset
REQ-014 While cpurst_b=0 at a clock edge, the block SHALL enter IDLE, clear the accumulator, counter and mul_rsp_data, and drive mul_rsp_vld=0, mul_busy=0, mul_req_rdy=1.
REQ-015 Reset mid-CALC or in DONE SHALL discard the operation; no response SHALL follow.

Configuration
REQ-016 With macro BOOTH_SEQ_EARLY_TERM_EN defined, CALC SHALL go to DONE after iteration i when all remaining multiplier bits b[24:2i+1] are equal; minimum 1 iteration, latency 1..13 cycles.
REQ-017 Without BOOTH_SEQ_EARLY_TERM_EN, latency SHALL be fixed at 13 cycles.
REQ-018 Results SHALL be identical with and without the macro.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the width constants (SRC 25, RES 50) and the iteration count (13).
REQ-020 Recoding SHALL use one sub-module instance, booth_code_25_bit, fed by the current 3-bit group and the latched A; the accumulator and FSM SHALL stay in this module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- A=3, B=5 -> rsp_data=15, rsp_vld 13 cycles after accept (non-ET build).
- A=0x1FFFFFF(-1), B=0x1FFFFFF(-1) -> rsp_data=1.
- A=0x1000000, B=0x1000000 (-2^24 each) -> rsp_data=0x1_0000_0000_0000.
- A=-7, B=9, rsp_rdy held low 5 cycles -> rsp_data=-63 held stable, req_rdy=0 throughout, IDLE one cycle after rsp_rdy=1.
- mul_flush at iteration 6 -> no rsp_vld; next op A=100, B=-3 -> rsp_data=-300.
- ET build, A=12345, B=1 -> rsp_data=12345 with rsp_vld 1 cycle after accept; B=0x0FFFFFF -> 13 cycles.
